// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package instr_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    ERROR
  } loader_state_e;

  localparam int INSTR_MEM_BYTES_DEFAULT = 32;
  localparam int INSTR_WORD_BYTES        = 4;

endpackage

// File: rtl/instr_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word/word_valid are
// combinational so the top can register the write in the same edge as the lane-3 byte.
module instr_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [1:0]  lane
);

  // Holds lanes 0..2 once three bytes have shifted in; lane 3 comes straight from data.
  logic [2:0][7:0] lanes_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lanes_q <= '0;
      lane    <= 2'd0;
    end else if (start) begin
      lanes_q <= '0;
      lane    <= 2'd0;
    end else if (accept) begin
      lanes_q <= {data, lanes_q[2:1]};
      lane    <= lane + 2'd1;
    end
  end

  assign word       = {data, lanes_q};
  assign word_valid = accept && (lane == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// Loads a byte stream into instruction memory and holds the CPU until done.
// Optional LOADER_CHECKSUM_EN: last word is an XOR checksum of the written words.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   LOAD  | accepting bytes, writing completed words
//   DONE  | program written, CPU released
//   ERROR | load aborted (partial word, overflow, bad checksum)
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int MEM_BYTES = INSTR_MEM_BYTES_DEFAULT
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [7:0]                                   in_data,
  input  logic                                         in_last,
  output logic                                         wr_en,
  output logic [63:0]                                  wr_addr,
  output logic [31:0]                                  wr_data,
  output logic                                         cpu_hold,
  output logic                                         done,
  output logic                                         error,
  output logic [$clog2(MEM_BYTES/INSTR_WORD_BYTES):0]  word_count
);

  localparam int MAX_WORDS = MEM_BYTES / INSTR_WORD_BYTES;
  localparam int WC_W      = $clog2(MAX_WORDS) + 1;

  loader_state_e state;
  logic [63:0]   addr_q;
  logic [31:0]   word;
  logic          word_valid;
  logic [1:0]    lane;
  logic          accept;
  logic          load_start;
  logic          in_bounds;
  logic          wr_fire;
  logic          go_done;
  logic          go_err;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   xor_q;
`endif

  assign accept     = in_valid & in_ready;
  assign load_start = start & (state != LOAD);
  assign in_bounds  = (addr_q + 64'd3) < 64'(MEM_BYTES);

  instr_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .start      (load_start),
    .accept     (accept),
    .data       (in_data),
    .word       (word),
    .word_valid (word_valid),
    .lane       (lane)
  );

  always_comb begin
    wr_fire = 1'b0;
    go_done = 1'b0;
    go_err  = 1'b0;
    if (state == LOAD && accept) begin
      if (in_last && lane != 2'd3) begin
        go_err = 1'b1;
      end else if (word_valid) begin
`ifdef LOADER_CHECKSUM_EN
        // The checksum word is never written, so it is exempt from the bounds check.
        if (in_last) begin
          if (word == xor_q) go_done = 1'b1;
          else               go_err  = 1'b1;
        end else if (!in_bounds) begin
          go_err = 1'b1;
        end else begin
          wr_fire = 1'b1;
        end
`else
        if (!in_bounds) begin
          go_err = 1'b1;
        end else begin
          wr_fire = 1'b1;
          go_done = in_last;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      addr_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      wr_en <= wr_fire;
      if (load_start) begin
        state      <= LOAD;
        in_ready   <= 1'b1;
        cpu_hold   <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
        word_count <= '0;
        addr_q     <= '0;
        wr_addr    <= '0;
`ifdef LOADER_CHECKSUM_EN
        xor_q      <= '0;
`endif
      end
      if (wr_fire) begin
        wr_addr <= addr_q;
        wr_data <= word;
        addr_q  <= addr_q + 64'd4;
        if (word_count != WC_W'(MAX_WORDS)) word_count <= word_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        xor_q   <= xor_q ^ word;
`endif
      end
      if (go_done) begin
        state    <= DONE;
        in_ready <= 1'b0;
        cpu_hold <= 1'b0;
        done     <= 1'b1;
      end
      if (go_err) begin
        state    <= ERROR;
        in_ready <= 1'b0;
        error    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: vector table, hand-written corner cases
// and randomized loads against an arithmetic reference model.
module tb_instr_loader;

  localparam int MEM  = 32;
  localparam int W    = MEM / 4;
  localparam int WC_W = $clog2(W) + 1;

  logic            clk = 1'b0;
  logic            reset, start, in_valid, in_last;
  logic [7:0]      in_data;
  logic            in_ready, wr_en, cpu_hold, done, error;
  logic [63:0]     wr_addr;
  logic [31:0]     wr_data;
  logic [WC_W-1:0] word_count;

  instr_loader #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [63:0] addr; logic [31:0] data;} wr_t;
  wr_t wq[$];

  always @(negedge clk) if (wr_en === 1'b1) wq.push_back('{wr_addr, wr_data});

  int total = 0;
  int bad   = 0;
  logic [7:0] prog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int i);
    return {prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]};
  endfunction

  // Expected outcome of a load of n bytes with in_last on byte n.
  task automatic model(input int n, output int acc, output int writes, output bit ok);
    int nw;
    logic [31:0] x;
    nw = n / 4;
    x  = '0;
`ifdef LOADER_CHECKSUM_EN
    if (n > 4*(W+1)) begin
      acc = 4*(W+1); writes = W; ok = 0;
    end else if (n % 4 != 0) begin
      acc = n; writes = nw; ok = 0;
    end else begin
      acc = n; writes = nw - 1;
      for (int i = 0; i < nw - 1; i++) x ^= pack(i);
      ok = (pack(nw-1) == x);
    end
`else
    if (nw > W) begin
      acc = 4*(W+1); writes = W; ok = 0;
    end else begin
      acc = n; writes = nw; ok = (n % 4 == 0);
    end
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit l, output bit got);
    in_valid = 1'b1; in_data = d; in_last = l; got = 0;
    for (int t = 0; t < 20; t++) begin
      if (in_ready === 1'b1) begin
        got = 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // gap: 0 back-to-back, 1 idle cycle after every byte, 2 random idle cycles
  task automatic load_bytes(input int n, input int nsend, input int gap);
    bit got;
    wq.delete();
    pulse_start();
    for (int i = 0; i < nsend; i++) begin
      send_byte(prog[i], (i == n-1), got);
      if (!got) begin
        chk("accept_timeout", 0, 1);
        break;
      end
      if (gap == 1) begin @(posedge clk); #1; end
      if (gap == 2) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_result(input int writes, input bit ok);
    chk("write_count", wq.size(), writes);
    for (int i = 0; i < writes && i < wq.size(); i++) begin
      chk("wr_addr", wq[i].addr, 64'(4*i));
      chk("wr_data", wq[i].data, pack(i));
    end
    chk("done", done, ok);
    chk("error", error, !ok);
    chk("cpu_hold", cpu_hold, !ok);
    chk("word_count", word_count, writes);
    chk("in_ready_idle", in_ready, 0);
  endtask

  task automatic fill_pattern(input int n, input int seed);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(8'(i*37 + 11 + seed*5));
  endtask

  typedef struct {int n; int nsend; int gap; bit exp_done; int exp_wc;} vec_t;
  vec_t tbl[$];

  initial begin
    int acc, writes, n;
    bit ok, got;
    logic [31:0] x;

`ifdef LOADER_CHECKSUM_EN
    tbl.push_back('{8,  8,  0, 1'b0, 1});
    tbl.push_back('{6,  6,  0, 1'b0, 1});
    tbl.push_back('{36, 36, 1, 1'b0, 8});
    tbl.push_back('{40, 36, 0, 1'b0, 8});
    tbl.push_back('{4,  4,  2, 1'b0, 0});
`else
    tbl.push_back('{4,  4,  0, 1'b1, 1});
    tbl.push_back('{32, 32, 1, 1'b1, 8});
    tbl.push_back('{36, 36, 0, 1'b0, 8});
    tbl.push_back('{6,  6,  0, 1'b0, 1});
    tbl.push_back('{9,  9,  2, 1'b0, 2});
    tbl.push_back('{2,  2,  0, 1'b0, 0});
    tbl.push_back('{40, 36, 0, 1'b0, 8});
`endif

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_word_count", word_count, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 0);

    // Basic load with exact output timing
    prog = '{8'h13, 8'h00, 8'h80, 8'h91};
    wq.delete();
    pulse_start();
    chk("start_in_ready", in_ready, 1);
`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < 4; i++) send_byte(prog[i], 1'b0, got);
    for (int i = 0; i < 4; i++) send_byte(prog[i], (i == 3), got);
    chk("cks_eq_wr_en", wr_en, 0);
    chk("cks_eq_done", done, 1);
    chk("cks_eq_hold", cpu_hold, 0);
    chk("cks_eq_count", word_count, 1);
`else
    for (int i = 0; i < 4; i++) send_byte(prog[i], (i == 3), got);
    chk("basic_wr_en", wr_en, 1);
    chk("basic_wr_addr", wr_addr, 0);
    chk("basic_wr_data", wr_data, 32'h91800013);
    chk("basic_done", done, 1);
    chk("basic_cpu_hold", cpu_hold, 0);
    chk("basic_word_count", word_count, 1);
    chk("basic_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("basic_wr_en_pulse", wr_en, 0);
    chk("basic_done_hold", done, 1);

    // start while loading must not restart the packer
    prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    wq.delete();
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(prog[i], 1'b0, got);
    pulse_start();
    send_byte(prog[3], 1'b1, got);
    repeat (2) @(posedge clk);
    #1;
    check_result(1, 1);
`endif

`ifdef LOADER_CHECKSUM_EN
    prog = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
             8'h03, 8'h00, 8'h00, 8'h00};
    load_bytes(12, 12, 0);
    check_result(2, 1);
    prog[8] = 8'h04;
    load_bytes(12, 12, 0);
    check_result(2, 0);
`endif

    foreach (tbl[k]) begin
      fill_pattern(tbl[k].n, k);
      load_bytes(tbl[k].n, tbl[k].nsend, tbl[k].gap);
      check_result(tbl[k].exp_wc, tbl[k].exp_done);
    end

    // Reset mid-load
    fill_pattern(8, 3);
    wq.delete();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(prog[i], 1'b0, got);
    reset = 1'b1;
    #2;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_cpu_hold", cpu_hold, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_word_count", word_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_writes", wq.size(), 1);
    chk("mid_rst_idle_ready", in_ready, 0);
`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < 4; i++) prog[i+4] = prog[i];
    load_bytes(8, 8, 0);
    check_result(1, 1);
`else
    load_bytes(4, 4, 0);
    check_result(1, 1);
`endif

    // Randomized loads against the model
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 44);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
      if (n % 4 == 0 && n <= 36 && $urandom_range(0, 1) == 1) begin
        x = '0;
        for (int i = 0; i < n/4 - 1; i++) x ^= pack(i);
        for (int b = 0; b < 4; b++) prog[n-4+b] = x[8*b +: 8];
      end
`else
      if ($urandom_range(0, 2) == 0) begin
        n = 4 * $urandom_range(1, W);
        while (prog.size() < n) prog.push_back(8'($urandom));
      end
`endif
      model(n, acc, writes, ok);
      load_bytes(n, acc, 2);
      check_result(writes, ok);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
